// File: rtl/wb_regfile.sv
// Write-back select plus 32x32 architectural register file with a committed-write counter.
// Optional write-through bypass on the read ports is enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [4:0]        WriteReg,
  input  logic [1:0]        WBControl,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData,
  output logic              WriteEn,
  output logic [CNT_W-1:0]  wb_count
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  assign WriteData = WBControl[0] ? ReadData : ALUResult;
  // Writes to $0 are dropped here, so they neither touch the array nor count.
  assign WriteEn   = WBControl[1] & (WriteReg != 5'd0) & ~rst;
  assign wb_count  = cnt_q;

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (WriteEn) begin
      regs_d[WriteReg] = WriteData;
      cnt_d            = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    ReadData1 = regs_q[ReadReg1];
    ReadData2 = regs_q[ReadReg2];
`ifdef WB_REGFILE_BYPASS_EN
    if (WriteEn && (ReadReg1 == WriteReg)) begin
      ReadData1 = WriteData;
    end
    if (WriteEn && (ReadReg2 == WriteReg)) begin
      ReadData2 = WriteData;
    end
`endif
    // $0 is forced last so it wins over both the array and the bypass.
    if (ReadReg1 == 5'd0) begin
      ReadData1 = '0;
    end
    if (ReadReg2 == 5'd0) begin
      ReadData2 = '0;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected values, a negedge monitor pops and compares.
// A second instance with a 4-bit counter shares all inputs to exercise counter wrap.
module tb_wb_regfile;

  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] read_data;
  logic [4:0]        write_reg;
  logic [1:0]        wb_control;
  logic [4:0]        read_reg1;
  logic [4:0]        read_reg2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] wdata;
  logic              wen;
  logic [31:0]       count;
  logic [DATA_W-1:0] s_rd1;
  logic [DATA_W-1:0] s_rd2;
  logic [DATA_W-1:0] s_wdata;
  logic              s_wen;
  logic [3:0]        s_count;

  int checks = 0;
  int errors = 0;

  typedef enum int {SEL_RD1, SEL_RD2, SEL_WDATA, SEL_WEN, SEL_CNT, SEL_SCNT} sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } chk_t;
  chk_t sb[$];

  wb_regfile dut (
    .clk(clk), .rst(rst), .ALUResult(alu_result), .ReadData(read_data),
    .WriteReg(write_reg), .WBControl(wb_control), .ReadReg1(read_reg1),
    .ReadReg2(read_reg2), .ReadData1(rd1), .ReadData2(rd2),
    .WriteData(wdata), .WriteEn(wen), .wb_count(count)
  );

  wb_regfile #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .ALUResult(alu_result), .ReadData(read_data),
    .WriteReg(write_reg), .WBControl(wb_control), .ReadReg1(read_reg1),
    .ReadReg2(read_reg2), .ReadData1(s_rd1), .ReadData2(s_rd2),
    .WriteData(s_wdata), .WriteEn(s_wen), .wb_count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every falling edge, drain everything stimulus queued for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = sb.pop_front();
      case (c.sel)
        SEL_RD1:   act = rd1;
        SEL_RD2:   act = rd2;
        SEL_WDATA: act = wdata;
        SEL_WEN:   act = {31'd0, wen};
        SEL_CNT:   act = count;
        default:   act = {28'd0, s_count};
      endcase
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] ctl, input logic [4:0] wreg,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic rst_in);
    wb_control = ctl;
    write_reg  = wreg;
    alu_result = alu;
    read_data  = mem;
    read_reg1  = r1;
    read_reg2  = r2;
    rst        = rst_in;
  endtask

  task automatic checkOutput(input string name, input sel_t sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    applyStimulus(2'b00, 5'd0, 32'h0, 32'h0, r1, r2, 1'b0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    applyStimulus(2'b10, 5'd3, 32'h1, 32'h2, 5'd0, 5'd0, 1'b1);
    step();

    for (int a = 0; a < 32; a++) begin
      idle(5'(a), 5'(31 - a));
      checkOutput("reset_rd1", SEL_RD1, 32'h0);
      checkOutput("reset_rd2", SEL_RD2, 32'h0);
      if (a == 0) begin
        checkOutput("reset_cnt", SEL_CNT, 32'h0);
        checkOutput("reset_wen", SEL_WEN, 32'h0);
      end
      step();
    end

    applyStimulus(2'b10, 5'h1F, 32'h12345678, 32'hABCDEF01, 5'd31, 5'd0, 1'b0);
    checkOutput("alu_wdata", SEL_WDATA, 32'h12345678);
    checkOutput("alu_wen", SEL_WEN, 32'h1);
    step();
    idle(5'd31, 5'd0);
    checkOutput("alu_rd1", SEL_RD1, 32'h12345678);
    checkOutput("alu_cnt", SEL_CNT, 32'd1);
    step();

    applyStimulus(2'b11, 5'h0A, 32'h00000055, 32'hFEDCBA98, 5'd0, 5'd0, 1'b0);
    checkOutput("load_wdata", SEL_WDATA, 32'hFEDCBA98);
    checkOutput("load_wen", SEL_WEN, 32'h1);
    step();
    idle(5'd10, 5'd0);
    checkOutput("load_rd1", SEL_RD1, 32'hFEDCBA98);
    checkOutput("load_cnt", SEL_CNT, 32'd2);
    step();

    applyStimulus(2'b11, 5'd0, 32'h00000077, 32'hCAFEF00D, 5'd0, 5'd0, 1'b0);
    checkOutput("zero_wen", SEL_WEN, 32'h0);
    checkOutput("zero_wdata", SEL_WDATA, 32'hCAFEF00D);
    checkOutput("zero_rd1_pre", SEL_RD1, 32'h0);
    step();
    idle(5'd0, 5'd0);
    checkOutput("zero_rd1", SEL_RD1, 32'h0);
    checkOutput("zero_cnt", SEL_CNT, 32'd2);
    step();

    applyStimulus(2'b01, 5'h0A, 32'h00000001, 32'h99999999, 5'd10, 5'd0, 1'b0);
    checkOutput("nowr_wen", SEL_WEN, 32'h0);
    checkOutput("nowr_wdata", SEL_WDATA, 32'h99999999);
    step();
    idle(5'd10, 5'd0);
    checkOutput("nowr_rd1", SEL_RD1, 32'hFEDCBA98);
    checkOutput("nowr_cnt", SEL_CNT, 32'd2);
    step();

    applyStimulus(2'b10, 5'd5, 32'h11111111, 32'h0, 5'd0, 5'd0, 1'b0);
    step();
    applyStimulus(2'b10, 5'd5, 32'h22222222, 32'h0, 5'd0, 5'd5, 1'b0);
`ifdef WB_REGFILE_BYPASS_EN
    checkOutput("same_rd2_pre", SEL_RD2, 32'h22222222);
`else
    checkOutput("same_rd2_pre", SEL_RD2, 32'h11111111);
`endif
    step();
    idle(5'd5, 5'd5);
    checkOutput("same_rd1_post", SEL_RD1, 32'h22222222);
    checkOutput("same_rd2_post", SEL_RD2, 32'h22222222);
    checkOutput("same_cnt", SEL_CNT, 32'd4);
    checkOutput("same_scnt", SEL_SCNT, 32'd4);
    step();

    applyStimulus(2'b10, 5'd3, 32'hDEADBEEF, 32'h0, 5'd0, 5'd0, 1'b1);
    checkOutput("rstcol_wen", SEL_WEN, 32'h0);
    checkOutput("rstcol_wdata", SEL_WDATA, 32'hDEADBEEF);
    step();
    idle(5'd3, 5'd5);
    checkOutput("rstcol_rd1", SEL_RD1, 32'h0);
    checkOutput("rstcol_rd2", SEL_RD2, 32'h0);
    checkOutput("rstcol_cnt", SEL_CNT, 32'd0);
    checkOutput("rstcol_scnt", SEL_SCNT, 32'd0);
    step();

    for (int i = 1; i <= 16; i++) begin
      applyStimulus(2'b10, 5'(i), 32'h1000 + 32'(i), 32'h0, 5'd0, 5'd0, 1'b0);
      step();
      if (i == 15) begin
        idle(5'd0, 5'd0);
        checkOutput("wrap_scnt15", SEL_SCNT, 32'd15);
        step();
      end
    end
    idle(5'd7, 5'd16);
    checkOutput("wrap_scnt", SEL_SCNT, 32'd0);
    checkOutput("wrap_cnt", SEL_CNT, 32'd16);
    checkOutput("wrap_rd1", SEL_RD1, 32'h00001007);
    checkOutput("wrap_rd2", SEL_RD2, 32'h00001010);
    step();

    step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
